bit_serializer_piso: RTL

- Parallel-in/serial-out stage that sits directly upstream of the 1101 sequence detector and produces its serial input x.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- A one-word holding register lets consecutive words stream without idle gaps between them.
- Drives a per-bit valid strobe and a running count of completed words.

---
 rtl/bit_serializer_piso_if.sv | 24 ++
 rtl/bit_serializer_piso.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bit_serializer_piso_if.sv
// Word-in / bit-out bus of the parallel-to-serial stage.
// The upstream word source uses the master view.
// The serializer uses the slave view.
interface bit_serializer_piso_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic [15:0]      word_cnt;

   modport master (
      output din, din_valid,
      input  din_ready, x, x_valid, busy, word_cnt
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x, x_valid, busy, word_cnt
   );
endinterface

// File: rtl/bit_serializer_piso.sv
// Parallel-in / serial-out stage feeding the 1101 sequence detector.
// It accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock.
// A one-word holding register keeps back-to-back words gap-free.
// x, x_valid and busy are registered, so din/din_valid never reach them combinationally.
module bit_serializer_piso #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   bit_serializer_piso_if.slave bus
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold_reg;
   logic             hold_full;
   logic [CW-1:0]    bit_cnt;
   logic             x_q;
   logic             x_valid_q;
   logic             busy_q;
   logic [15:0]      word_cnt_q;

   logic             accept;
   logic [WIDTH-1:0] shifted;

   // Bit presented on x while a given word occupies the shift register.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Ready depends only on registered state, never on din_valid.
   assign bus.din_ready = !hold_full;
   assign accept        = bus.din_valid && !hold_full;

   assign bus.x         = x_q;
   assign bus.x_valid   = x_valid_q;
   assign bus.busy      = busy_q;
   assign bus.word_cnt  = word_cnt_q;

   // Shift register advanced by one bit toward the output end.
   always_comb begin
      shifted = shreg;
      if (MSB_FIRST) begin
         shifted = {shreg[WIDTH-2:0], 1'b0};
      end else begin
         shifted = {1'b0, shreg[WIDTH-1:1]};
      end
   end

   // Control FSM.
   // It also handles the shift/hold datapath and the registered outputs.
   // x is loaded with the bit of the word that becomes current at this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         hold_reg   <= '0;
         hold_full  <= 1'b0;
         bit_cnt    <= '0;
         x_q        <= IDLE_LEVEL;
         x_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg     <= bus.din;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
                  x_q       <= out_bit(bus.din);
                  x_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
               end else begin
                  x_q       <= IDLE_LEVEL;
                  x_valid_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end

            SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  word_cnt_q <= word_cnt_q + 16'd1;
                  bit_cnt    <= '0;
                  if (hold_full) begin
                     shreg     <= hold_reg;
                     hold_full <= 1'b0;
                     x_q       <= out_bit(hold_reg);
                     x_valid_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end else if (accept) begin
                     shreg     <= bus.din;
                     x_q       <= out_bit(bus.din);
                     x_valid_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end else begin
                     state     <= IDLE;
                     x_q       <= IDLE_LEVEL;
                     x_valid_q <= 1'b0;
                     busy_q    <= 1'b0;
                  end
               end else begin
                  shreg     <= shifted;
                  bit_cnt   <= bit_cnt + CW'(1);
                  x_q       <= out_bit(shifted);
                  x_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  if (accept) begin
                     hold_reg  <= bus.din;
                     hold_full <= 1'b1;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               hold_full <= 1'b0;
               x_q       <= IDLE_LEVEL;
               x_valid_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Structural invariants between the FSM state and the registered outputs.
   a_hold_only_in_shift : assert property (@(posedge clk) disable iff (!reset)
      hold_full |-> (state == SHIFT));
   a_busy_matches_state : assert property (@(posedge clk) disable iff (!reset)
      busy_q == ((state == SHIFT) || hold_full));
   a_valid_matches_state : assert property (@(posedge clk) disable iff (!reset)
      x_valid_q == (state == SHIFT));
   a_x_tracks_shreg : assert property (@(posedge clk) disable iff (!reset)
      (state == SHIFT) |-> (x_q == out_bit(shreg)));
   a_idle_level : assert property (@(posedge clk) disable iff (!reset)
      (state == IDLE) |-> (x_q == IDLE_LEVEL));

endmodule
